// File: rtl/rf_wport_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wport_sched_pkg
// Brief    : Shared register-file constants and the write-request entry type.
// Revision : 1.0 - initial release
// ============================================================================
package rf_wport_sched_pkg;

   localparam int              REG_AW   = 5;
   localparam int              NUM_REGS = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
   localparam int              RF_DW    = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [RF_DW-1:0]  data;
   } wreq_t;

endpackage
`default_nettype wire

// File: rtl/rf_wbuf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rf_wbuf_fifo
// Brief    : DEPTH-entry FIFO of write requests; push and pop may coincide.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wbuf_fifo
   import rf_wport_sched_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type ENTRY_T = wreq_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  ENTRY_T wdata,
   input  logic   pop,
   output ENTRY_T rdata,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   ENTRY_T         r_mem [DEPTH];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [AW:0]    r_cnt;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (push) r_wptr <= r_wptr + 1'b1;
         if (pop)  r_rptr <= r_rptr + 1'b1;
         case ({push, pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) r_mem[r_wptr] <= wdata;
   end

   assign rdata = r_mem[r_rptr];
   assign full  = (r_cnt == (AW+1)'(DEPTH));
   assign empty = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/rf_wport_sched.sv
`default_nettype none
// ============================================================================
// Module   : rf_wport_sched
// Brief    : Shares the single RF write port between WB and buffered MDU
//            results; tracks MDU destinations and guards against starvation.
//            Optional macro RFSCHED_PERF_EN adds stall/hold perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wport_sched
   import rf_wport_sched_pkg::*;
#(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4,
   parameter int DW       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DW-1:0]     wb_data,
   input  logic              mdu_valid,
   input  logic [REG_AW-1:0] mdu_rd,
   input  logic [DW-1:0]     mdu_data,
   output logic              mdu_ready,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] dec_rs,
   input  logic [REG_AW-1:0] dec_rt,
   input  logic [REG_AW-1:0] dec_r3,
   output logic              dec_stall,
   output logic              wb_hold,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_wadd,
   output logic [DW-1:0]     rf_wdata
`ifdef RFSCHED_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_hold_cnt
`endif
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [DW-1:0]     data;
   } ent_t;

   ent_t                w_push_ent;
   ent_t                w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_pop_hold;
   logic                w_wb_win;
   logic                w_inc;
   logic                w_set;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic [NUM_REGS-1:0] r_busy;
   logic [WCW-1:0]      r_wait_cnt;
   logic                r_hold_q;

   assign w_push_ent = '{rd: mdu_rd, data: mdu_data};

   rf_wbuf_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_T (ent_t)
   ) u_wbuf (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .wdata (w_push_ent),
      .pop   (w_pop),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   assign mdu_ready  = !w_full;
   assign w_push     = !rst && mdu_valid && !w_full && (mdu_rd != REG_ZERO);

   // A held cycle forces the buffer head out; the frozen WB re-presents later.
   assign w_pop_hold = r_hold_q && !w_empty;
   assign w_wb_win   = !rst && !w_pop_hold && wb_we && (wb_rd != REG_ZERO);
   assign w_pop      = !rst && !w_empty && !w_wb_win;

   assign rf_we    = w_wb_win || w_pop;
   assign rf_wadd  = w_pop ? w_head.rd   : (w_wb_win ? wb_rd   : '0);
   assign rf_wdata = w_pop ? w_head.data : (w_wb_win ? wb_data : '0);
   assign wb_hold  = r_hold_q;

   assign dec_stall = r_busy[dec_rs] | r_busy[dec_rt] | r_busy[dec_r3]
                    | (iss_valid & r_busy[iss_rd]);

   assign w_set = iss_valid && !dec_stall && (iss_rd != REG_ZERO);
   assign w_inc = !w_empty && w_wb_win;

   always_comb begin
      w_busy_nxt = r_busy;
      if (w_pop) w_busy_nxt[w_head.rd] = 1'b0;
      if (w_set) w_busy_nxt[iss_rd]    = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy     <= '0;
         r_wait_cnt <= '0;
         r_hold_q   <= 1'b0;
      end else begin
         r_busy   <= w_busy_nxt;
         r_hold_q <= w_inc && (r_wait_cnt == WCW'(MAX_WAIT - 1));
         if (w_pop || w_empty) r_wait_cnt <= '0;
         else if (w_inc)       r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

`ifdef RFSCHED_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_hold_cnt  <= '0;
      end else begin
         if (dec_stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
         if (r_hold_q  && (perf_hold_cnt  != '1)) perf_hold_cnt  <= perf_hold_cnt  + 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wport_sched
// Brief    : Scoreboard bench for rf_wport_sched against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wport_sched;

   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;

   typedef struct packed {
      bit        rst;
      bit        wwe;
      bit [4:0]  wrd;
      bit [31:0] wd;
      bit        mv;
      bit [4:0]  mrd;
      bit [31:0] md;
      bit        iv;
      bit [4:0]  ird;
      bit [4:0]  rs;
      bit [4:0]  rt;
      bit [4:0]  r3;
   } stim_t;

   typedef struct packed {
      bit        we;
      bit [4:0]  wadd;
      bit [31:0] wdata;
      bit        hold;
      bit        stall;
      bit        ready;
   } exp_t;

   typedef struct packed {
      bit [4:0]  rd;
      bit [31:0] data;
   } ment_t;

   logic        clk;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  dec_rs;
   logic [4:0]  dec_rt;
   logic [4:0]  dec_r3;
   logic        dec_stall;
   logic        wb_hold;
   logic        rf_we;
   logic [4:0]  rf_wadd;
   logic [31:0] rf_wdata;
`ifdef RFSCHED_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_hold_cnt;
`endif

   rf_wport_sched #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .DW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .mdu_valid (mdu_valid),
      .mdu_rd    (mdu_rd),
      .mdu_data  (mdu_data),
      .mdu_ready (mdu_ready),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .dec_rs    (dec_rs),
      .dec_rt    (dec_rt),
      .dec_r3    (dec_r3),
      .dec_stall (dec_stall),
      .wb_hold   (wb_hold),
      .rf_we     (rf_we),
      .rf_wadd   (rf_wadd),
      .rf_wdata  (rf_wdata)
`ifdef RFSCHED_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_hold_cnt  (perf_hold_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    total = 0;
   int    bad   = 0;
   exp_t  exp_q [$];
   exp_t  mon_e;

   // Reference model state: pending MDU results in arrival order, busy set,
   // and how many cycles the oldest result has been passed over.
   ment_t mq [$];
   bit    busy_m [32];
   int    starve;
   bit    hold_m;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("rf_we",     32'(rf_we),     32'(mon_e.we));
         chk("rf_wadd",   32'(rf_wadd),   32'(mon_e.wadd));
         chk("rf_wdata",  rf_wdata,       mon_e.wdata);
         chk("wb_hold",   32'(wb_hold),   32'(mon_e.hold));
         chk("dec_stall", 32'(dec_stall), 32'(mon_e.stall));
         chk("mdu_ready", 32'(mdu_ready), 32'(mon_e.ready));
      end
   end

   task automatic step(input stim_t s);
      exp_t  e;
      ment_t popped;
      bit    did_pop, wb_won, stall, wb_req;
      int    n;
      rst = s.rst; wb_we = s.wwe; wb_rd = s.wrd; wb_data = s.wd;
      mdu_valid = s.mv; mdu_rd = s.mrd; mdu_data = s.md;
      iss_valid = s.iv; iss_rd = s.ird;
      dec_rs = s.rs; dec_rt = s.rt; dec_r3 = s.r3;
      e = '0;
      popped = '0;
      if (s.rst) begin
         e.ready = 1'b1;
         mq.delete();
         foreach (busy_m[i]) busy_m[i] = 1'b0;
         starve = 0;
         hold_m = 1'b0;
      end else begin
         n       = mq.size();
         stall   = busy_m[s.rs] || busy_m[s.rt] || busy_m[s.r3] || (s.iv && busy_m[s.ird]);
         wb_req  = s.wwe && (s.wrd != 0);
         e.ready = (n < DEPTH);
         e.stall = stall;
         e.hold  = hold_m;
         did_pop = 1'b0;
         wb_won  = 1'b0;
         if (n > 0 && (hold_m || !wb_req)) begin
            popped  = mq.pop_front();
            did_pop = 1'b1;
            e.we = 1'b1; e.wadd = popped.rd; e.wdata = popped.data;
         end else if (wb_req) begin
            wb_won = 1'b1;
            e.we = 1'b1; e.wadd = s.wrd; e.wdata = s.wd;
         end
         if (s.mv && n < DEPTH && s.mrd != 0) mq.push_back('{rd: s.mrd, data: s.md});
         if (did_pop) busy_m[popped.rd] = 1'b0;
         if (s.iv && !stall && s.ird != 0) busy_m[s.ird] = 1'b1;
         hold_m = 1'b0;
         if (did_pop || n == 0) starve = 0;
         else if (wb_won) begin
            hold_m = (starve == MAX_WAIT - 1);
            starve++;
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   stim_t s;

   initial begin
      rst = 1'b1; wb_we = 0; wb_rd = 0; wb_data = 0; mdu_valid = 0; mdu_rd = 0;
      mdu_data = 0; iss_valid = 0; iss_rd = 0; dec_rs = 0; dec_rt = 0; dec_r3 = 0;
      starve = 0; hold_m = 0;
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      @(posedge clk);
      #1;

      // reset state
      s = '0; s.rst = 1; step(s); step(s);
      s = '0; step(s);

      // single MDU result, no WB
      s = '0; s.mv = 1; s.mrd = 5; s.md = 32'h1234; step(s);
      s = '0; step(s); step(s);

      // RAW stall on an issued MDU destination
      s = '0; s.iv = 1; s.ird = 7; step(s);
      s = '0; s.rs = 7; step(s); step(s);
      s.mv = 1; s.mrd = 7; s.md = 32'hcafe_0007; step(s);
      s.mv = 0; step(s); step(s);

      // WB every cycle while one MDU result waits
      s = '0; s.wwe = 1; s.wrd = 1; s.wd = 32'h1111_0000;
      s.mv = 1; s.mrd = 3; s.md = 32'h0000_0333; step(s);
      s.mv = 0;
      for (int i = 0; i < 8; i++) begin s.wd = 32'h1111_0001 + 32'(i); step(s); end

      // fill the buffer, reject a third result, then push+pop together
      s = '0; s.wwe = 1; s.wrd = 2; s.wd = 32'h2222;
      for (int i = 0; i < 7; i++) begin
         s.mv = 1; s.mrd = 5'(10 + i); s.md = 32'ha000 + 32'(i); step(s);
      end
      s.wwe = 0;
      for (int i = 0; i < 3; i++) begin
         s.mv = 1; s.mrd = 5'(20 + i); s.md = 32'hb000 + 32'(i); step(s);
      end
      s = '0; step(s); step(s); step(s);

      // r0 destinations never write and never mark busy
      s = '0; s.wwe = 1; s.wrd = 0; s.wd = 32'hdead; s.mv = 1; s.mrd = 0;
      s.iv = 1; s.ird = 0; step(s); step(s);
      s = '0; s.rs = 0; s.iv = 1; s.ird = 0; step(s);

      // reset mid-operation with two buffered results and busy[9]
      s = '0; s.wwe = 1; s.wrd = 1; s.wd = 32'h5;
      s.mv = 1; s.mrd = 4; s.md = 32'h44; s.iv = 1; s.ird = 9; step(s);
      s.iv = 0; s.mrd = 6; s.md = 32'h66; step(s);
      s.mv = 0; s.rs = 9; s.rst = 1; step(s); step(s);
      s = '0; s.rs = 9; step(s); step(s);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s = '0;
         s.rst = ($urandom_range(0, 299) == 0);
         s.wwe = ($urandom_range(0, 9) < 6);
         s.wrd = 5'($urandom_range(0, 7));
         s.wd  = $urandom;
         s.mv  = ($urandom_range(0, 9) < 4);
         s.mrd = 5'($urandom_range(0, 7));
         s.md  = $urandom;
         s.iv  = ($urandom_range(0, 9) < 3);
         s.ird = 5'($urandom_range(0, 7));
         s.rs  = 5'($urandom_range(0, 7));
         s.rt  = 5'($urandom_range(0, 7));
         s.r3  = 5'($urandom_range(0, 31));
         step(s);
      end

      @(negedge clk);
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
